// File: rtl/simd_decode_queue_if.sv
// +------------------------------------------------------------------+
// | simd_decode_queue_if                                             |
// | Producer/consumer bundle for the decoded-instruction queue.      |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

interface simd_decode_queue_if #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 9
);
    localparam int c_cnt_w = $clog2(DEPTH) + 1;

    logic               flush;
    logic               in_valid;
    logic               in_ready;
    logic [31:0]        instruction;
    logic               out_valid;
    logic               out_ready;
    logic [3:0]         type_instruction;
    logic [4:0]         regnum_1;
    logic [4:0]         regnum_2;
    logic [4:0]         dest_reg;
    logic [5:0]         shammt;
    logic [ADDR_W-1:0]  address;
    logic [11:0]        immediate;
    logic               illegal;
    logic [c_cnt_w-1:0] count;

    modport master (
        output flush, in_valid, instruction, out_ready,
        input  in_ready, out_valid, type_instruction, regnum_1, regnum_2,
               dest_reg, shammt, address, immediate, illegal, count
    );

    modport slave (
        input  flush, in_valid, instruction, out_ready,
        output in_ready, out_valid, type_instruction, regnum_1, regnum_2,
               dest_reg, shammt, address, immediate, illegal, count
    );
endinterface

`default_nettype wire

// File: rtl/simd_decode_queue.sv
// +------------------------------------------------------------------+
// | simd_decode_queue                                                |
// | Decodes instructions on accept and queues the decoded fields in  |
// | a circular buffer. Optional immediate decode: SIMD_DECODE_IMM_EN |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module simd_decode_queue #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 9
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    simd_decode_queue_if.slave q
);
    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;
    localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(DEPTH);

    localparam logic [3:0] c_type_add  = 4'b0000;
    localparam logic [3:0] c_type_sub  = 4'b0001;
    localparam logic [3:0] c_type_mul  = 4'b0010;
    localparam logic [3:0] c_type_udiv = 4'b0011;
    localparam logic [3:0] c_type_fadd = 4'b0100;
    localparam logic [3:0] c_type_fsub = 4'b0101;
    localparam logic [3:0] c_type_load = 4'b0110;
    localparam logic [3:0] c_type_ret  = 4'b0111;
`ifdef SIMD_DECODE_IMM_EN
    localparam logic [3:0] c_type_addi = 4'b1000;
    localparam logic [3:0] c_type_subi = 4'b1001;
`endif
    localparam logic [3:0] c_type_ill  = 4'b1111;

    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;

    logic [3:0]        r_type_mem    [DEPTH];
    logic              r_illegal_mem [DEPTH];
    logic [4:0]        r_rn1_mem     [DEPTH];
    logic [4:0]        r_rn2_mem     [DEPTH];
    logic [4:0]        r_dest_mem    [DEPTH];
    logic [5:0]        r_sh_mem      [DEPTH];
    logic [ADDR_W-1:0] r_addr_mem    [DEPTH];
`ifdef SIMD_DECODE_IMM_EN
    logic [11:0]       r_imm_mem     [DEPTH];
`endif

    logic [3:0]         w_type;
    logic               w_illegal;
    logic               w_in_ready;
    logic               w_push;
    logic               w_pop;
    logic [c_ptr_w-1:0] w_rd_idx;

    always_comb begin
        w_type = c_type_ill;
        unique case (q.instruction[31:21])
            11'b10001011000: w_type = c_type_add;
            11'b11001011000: w_type = c_type_sub;
            11'b10011011000: w_type = c_type_mul;
            11'b10011010110: w_type = c_type_udiv;
            11'b11010110010: w_type = c_type_ret;
            11'b10101010101: w_type = c_type_load;
            11'b00011110011: begin
                if (q.instruction[15:10] == 6'b001010) begin
                    w_type = c_type_fadd;
                end else if (q.instruction[15:10] == 6'b001110) begin
                    w_type = c_type_fsub;
                end
            end
            default: begin
`ifdef SIMD_DECODE_IMM_EN
                // Immediate forms use a 10-bit opcode; bit 21 is immediate data
                if (q.instruction[31:22] == 10'b1001000100) begin
                    w_type = c_type_addi;
                end else if (q.instruction[31:22] == 10'b1101000100) begin
                    w_type = c_type_subi;
                end
`endif
            end
        endcase
        w_illegal = (w_type == c_type_ill);
    end

    assign w_in_ready = (r_count < c_depth);
    assign w_push     = q.in_valid && w_in_ready;
    assign w_pop      = (r_count != '0) && q.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (q.flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + c_cnt_w'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - c_cnt_w'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_type_mem[i]    <= '0;
                r_illegal_mem[i] <= 1'b0;
                r_rn1_mem[i]     <= '0;
                r_rn2_mem[i]     <= '0;
                r_dest_mem[i]    <= '0;
                r_sh_mem[i]      <= '0;
                r_addr_mem[i]    <= '0;
`ifdef SIMD_DECODE_IMM_EN
                r_imm_mem[i]     <= '0;
`endif
            end
        end else if (w_push && !q.flush) begin
            r_type_mem[r_wr_ptr]    <= w_type;
            r_illegal_mem[r_wr_ptr] <= w_illegal;
            r_rn1_mem[r_wr_ptr]     <= q.instruction[9:5];
            r_rn2_mem[r_wr_ptr]     <= q.instruction[20:16];
            r_dest_mem[r_wr_ptr]    <= q.instruction[4:0];
            r_sh_mem[r_wr_ptr]      <= q.instruction[15:10];
            r_addr_mem[r_wr_ptr]    <= q.instruction[12 +: ADDR_W];
`ifdef SIMD_DECODE_IMM_EN
            r_imm_mem[r_wr_ptr]     <= q.instruction[21:10];
`endif
        end
    end

    // When empty, point at the most recently removed slot so fields hold
    assign w_rd_idx = (r_count == '0) ? (r_rd_ptr - c_ptr_w'(1)) : r_rd_ptr;

    assign q.in_ready         = w_in_ready;
    assign q.out_valid        = (r_count != '0);
    assign q.count            = r_count;
    assign q.type_instruction = r_type_mem[w_rd_idx];
    assign q.illegal          = r_illegal_mem[w_rd_idx];
    assign q.regnum_1         = r_rn1_mem[w_rd_idx];
    assign q.regnum_2         = r_rn2_mem[w_rd_idx];
    assign q.dest_reg         = r_dest_mem[w_rd_idx];
    assign q.shammt           = r_sh_mem[w_rd_idx];
    assign q.address          = r_addr_mem[w_rd_idx];
`ifdef SIMD_DECODE_IMM_EN
    assign q.immediate        = r_imm_mem[w_rd_idx];
`else
    assign q.immediate        = 12'h000;
`endif

endmodule

`default_nettype wire

// File: tb/tb_simd_decode_queue.sv
// Self-checking bench for simd_decode_queue: directed scenarios plus
// randomized traffic against a queue-of-raw-words reference model.
`default_nettype none
`timescale 1ns/1ps

module tb_simd_decode_queue;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 9;
    localparam int FW     = 38 + ADDR_W;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;
    logic [31:0] mq[$];

    always #5 clk = ~clk;

    simd_decode_queue_if #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) bus();

    simd_decode_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .q     (bus)
    );

    logic [FW-1:0] obs;
    assign obs = {bus.type_instruction, bus.illegal, bus.regnum_1, bus.regnum_2,
                  bus.dest_reg, bus.shammt, bus.address, bus.immediate};

    // Expected decoded field vector for a raw word, straight from the opcode table
    function automatic logic [FW-1:0] model_fields(input logic [31:0] w);
        logic [3:0]  t;
        logic [11:0] imm;
        t   = 4'hF;
        imm = 12'h000;
        if      (w[31:21] == 11'b10001011000) t = 4'd0;
        else if (w[31:21] == 11'b11001011000) t = 4'd1;
        else if (w[31:21] == 11'b10011011000) t = 4'd2;
        else if (w[31:21] == 11'b10011010110) t = 4'd3;
        else if (w[31:21] == 11'b11010110010) t = 4'd7;
        else if (w[31:21] == 11'b10101010101) t = 4'd6;
        else if (w[31:21] == 11'b00011110011 && w[15:10] == 6'b001010) t = 4'd4;
        else if (w[31:21] == 11'b00011110011 && w[15:10] == 6'b001110) t = 4'd5;
`ifdef SIMD_DECODE_IMM_EN
        else if (w[31:22] == 10'b1001000100) t = 4'd8;
        else if (w[31:22] == 10'b1101000100) t = 4'd9;
        imm = w[21:10];
`endif
        return {t, (t == 4'hF), w[9:5], w[20:16], w[4:0], w[15:10], w[12 +: ADDR_W], imm};
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        w = $urandom();
        case ($urandom_range(0, 9))
            0: w[31:21] = 11'b10001011000;
            1: w[31:21] = 11'b11001011000;
            2: w[31:21] = 11'b10011011000;
            3: w[31:21] = 11'b10011010110;
            4: w[31:21] = 11'b11010110010;
            5: w[31:21] = 11'b10101010101;
            6: begin
                w[31:21] = 11'b00011110011;
                w[15:10] = ($urandom_range(0, 1) != 0) ? 6'b001010 : 6'b001110;
            end
            7: w[31:22] = 10'b1001000100;
            8: w[31:22] = 10'b1101000100;
            default: ;
        endcase
        return w;
    endfunction

    // One clock edge; the model applies what the inputs requested before it
    task automatic tick();
        int n;
        bit acc, rem, fl;
        logic [31:0] w;
        n   = mq.size();
        acc = bus.in_valid && (n < DEPTH);
        rem = bus.out_ready && (n != 0);
        fl  = bus.flush;
        w   = bus.instruction;
        @(posedge clk);
        #1;
        if (fl) mq.delete();
        else begin
            if (rem) void'(mq.pop_front());
            if (acc) mq.push_back(w);
        end
    endtask

    task automatic idle();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.flush     = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        bus.instruction = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        mq.delete();
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
        total++; if (bus.count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", bus.count); end
        total++; if (obs !== '0) begin bad++; $display("FAIL reset_fields got=%h exp=0", obs); end
        rst_n = 1'b1;
        bus.in_valid = 1'b1;
        bus.instruction = rand_instr();
        tick();
        bus.in_valid = 1'b0;
        total++; if (bus.count !== 3'd1) begin bad++; $display("FAIL first_accept_count got=%0d exp=1", bus.count); end
        total++; if (obs !== model_fields(mq[0])) begin bad++; $display("FAIL first_accept_head got=%h exp=%h", obs, model_fields(mq[0])); end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_single();
        bus.in_valid = 1'b1;
        bus.instruction = 32'h8B020020;
        tick();
        bus.in_valid = 1'b0;
        total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL add_out_valid got=%b exp=1", bus.out_valid); end
        total++; if ({bus.type_instruction, bus.dest_reg, bus.regnum_1, bus.regnum_2, bus.illegal} !== {4'h0, 5'd0, 5'd1, 5'd2, 1'b0})
            begin bad++; $display("FAIL add_fields got=%h/%0d/%0d/%0d/%b exp=0/0/1/2/0", bus.type_instruction, bus.dest_reg, bus.regnum_1, bus.regnum_2, bus.illegal); end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL add_drained got=%b exp=0", bus.out_valid); end
    endtask

    task automatic test_full();
        logic [31:0] words [5];
        for (int i = 0; i < 5; i++) begin
            words[i] = rand_instr();
            bus.in_valid = 1'b1;
            bus.instruction = words[i];
            total++; if (bus.in_ready !== (i < 4)) begin bad++; $display("FAIL full_in_ready[%0d] got=%b exp=%b", i, bus.in_ready, (i < 4)); end
            tick();
        end
        bus.in_valid = 1'b0;
        total++; if (bus.count !== 3'd4) begin bad++; $display("FAIL full_count got=%0d exp=4", bus.count); end
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            total++; if (obs !== model_fields(words[i])) begin bad++; $display("FAIL full_order[%0d] got=%h exp=%h", i, obs, model_fields(words[i])); end
            tick();
        end
        bus.out_ready = 1'b0;
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL full_empty got=%b exp=0", bus.out_valid); end
    endtask

    task automatic test_back_to_back();
        bus.in_valid = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            bus.instruction = rand_instr();
            tick();
        end
        bus.out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            bus.instruction = rand_instr();
            total++; if (bus.in_ready !== (c != 0)) begin bad++; $display("FAIL b2b_in_ready[%0d] got=%b exp=%b", c, bus.in_ready, (c != 0)); end
            total++; if (obs !== model_fields(mq[0])) begin bad++; $display("FAIL b2b_head[%0d] got=%h exp=%h", c, obs, model_fields(mq[0])); end
            tick();
            total++; if (bus.count !== 3'd3) begin bad++; $display("FAIL b2b_count[%0d] got=%0d exp=3", c, bus.count); end
        end
        bus.in_valid = 1'b0;
        for (int c = 0; c < 8 && mq.size() != 0; c++) begin
            total++; if (obs !== model_fields(mq[0])) begin bad++; $display("FAIL b2b_drain[%0d] got=%h exp=%h", c, obs, model_fields(mq[0])); end
            tick();
        end
        bus.out_ready = 1'b0;
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL b2b_empty got=%b exp=0", bus.out_valid); end
    endtask

    task automatic test_fp_illegal();
        logic [31:0] words [3];
        logic [4:0]  exp_ti [3];
        words[0] = 32'h1E632820; exp_ti[0] = {4'h4, 1'b0};
        words[1] = 32'h1E633820; exp_ti[1] = {4'h5, 1'b0};
        words[2] = 32'hFFFFFFFF; exp_ti[2] = {4'hF, 1'b1};
        bus.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.instruction = words[i];
            tick();
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            total++; if ({bus.type_instruction, bus.illegal} !== exp_ti[i])
                begin bad++; $display("FAIL fp_ill_type[%0d] got=%h/%b exp=%h/%b", i, bus.type_instruction, bus.illegal, exp_ti[i][4:1], exp_ti[i][0]); end
            tick();
        end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_imm();
        logic [15:0] exp_v;
`ifdef SIMD_DECODE_IMM_EN
        exp_v = {4'h8, 12'h00A};
`else
        exp_v = {4'hF, 12'h000};
`endif
        bus.in_valid = 1'b1;
        bus.instruction = 32'h91002820;
        tick();
        bus.in_valid = 1'b0;
        total++; if ({bus.type_instruction, bus.immediate} !== exp_v)
            begin bad++; $display("FAIL imm_decode got=%h/%h exp=%h/%h", bus.type_instruction, bus.immediate, exp_v[15:12], exp_v[11:0]); end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_flush();
        logic [31:0] w;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.instruction = rand_instr();
            tick();
        end
        total++; if (bus.count !== 3'd3) begin bad++; $display("FAIL flush_pre_count got=%0d exp=3", bus.count); end
        bus.flush = 1'b1;
        bus.instruction = rand_instr();
        tick();
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        total++; if ({bus.count, bus.out_valid} !== {3'd0, 1'b0}) begin bad++; $display("FAIL flush_clear got=%0d/%b exp=0/0", bus.count, bus.out_valid); end
        w = rand_instr();
        bus.in_valid = 1'b1;
        bus.instruction = w;
        tick();
        bus.in_valid = 1'b0;
        total++; if ({bus.count, obs} !== {3'd1, model_fields(w)}) begin bad++; $display("FAIL flush_after got=%0d/%h exp=1/%h", bus.count, obs, model_fields(w)); end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        bus.in_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            bus.instruction = rand_instr();
            tick();
        end
        idle();
        #3;
        rst_n = 1'b0;
        #1;
        mq.delete();
        total++; if ({bus.out_valid, bus.in_ready, bus.count} !== {1'b0, 1'b1, 3'd0})
            begin bad++; $display("FAIL async_reset got=%b/%b/%0d exp=0/1/0", bus.out_valid, bus.in_ready, bus.count); end
        total++; if (obs !== '0) begin bad++; $display("FAIL async_reset_fields got=%h exp=0", obs); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            bus.in_valid    = ($urandom_range(0, 3) != 0);
            bus.out_ready   = ($urandom_range(0, 2) != 0);
            bus.flush       = ($urandom_range(0, 49) == 0);
            bus.instruction = rand_instr();
            total++; if ({bus.in_ready, bus.out_valid, bus.count} !== {(mq.size() < DEPTH), (mq.size() != 0), 3'(mq.size())})
                begin bad++; $display("FAIL rand_status[%0d] got=%b/%b/%0d exp=%b/%b/%0d", c, bus.in_ready, bus.out_valid, bus.count, (mq.size() < DEPTH), (mq.size() != 0), mq.size()); end
            if (mq.size() != 0) begin
                total++; if (obs !== model_fields(mq[0])) begin bad++; $display("FAIL rand_head[%0d] got=%h exp=%h", c, obs, model_fields(mq[0])); end
            end
            tick();
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_single();
        test_full();
        test_back_to_back();
        test_fp_illegal();
        test_imm();
        test_flush();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/simd_decode_queue.md
SIMD_DECODE_QUEUE -- requirements
Module: simd_decode_queue

Interface
REQ-001 SHALL provide parameter DEPTH, default 4, the number of decoded-instruction entries (power of two, minimum 2).
REQ-002 SHALL provide parameter ADDR_W, default 9, the width of the load-address field.
REQ-003 SHALL provide port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL provide port rst_n, input, 1, the asynchronous active-low reset.
REQ-005 SHALL provide port flush, input, 1, a synchronous clear of all queue contents.
REQ-006 SHALL provide port in_valid, input, 1, meaning an instruction is offered.
REQ-007 SHALL provide port in_ready, output, 1, meaning the queue can accept an instruction.
REQ-008 SHALL provide port instruction, input, 32, the raw instruction word.
REQ-009 SHALL provide port out_valid, output, 1, meaning the head entry is valid.
REQ-010 SHALL provide port out_ready, input, 1, meaning the consumer takes the head entry.
REQ-011 SHALL provide port type_instruction, output, 4, the decoded operation class.
REQ-012 SHALL provide ports regnum_1, regnum_2 and dest_reg, output, 5 each, the source and destination register numbers.
REQ-013 SHALL provide port shammt, output, 6, the shift-amount field.
REQ-014 SHALL provide port address, output, ADDR_W, the load address.
REQ-015 SHALL provide port immediate, output, 12, the immediate field.
REQ-016 SHALL provide port illegal, output, 1, meaning the head entry has an unrecognised opcode.
REQ-017 SHALL provide port count, output, $clog2(DEPTH)+1, the current number of occupied entries.

Function
REQ-018 SHALL decode each instruction when it is accepted (in_valid && in_ready) and store the decoded fields, not the raw word, in a circular buffer.
REQ-019 SHALL decode [31:21] as follows: 10001011000→0000 ADD; 11001011000→0001 SUB; 10011011000→0010 MUL; 10011010110→0011 UDIV; 11010110010→0111 RET; 10101010101→0110 LOAD.
REQ-020 SHALL decode [31:21]=00011110011 as 0100 FADD when [15:10]=001010 and as 0101 FSUB when [15:10]=001110.
REQ-021 SHALL map every other encoding to type 1111 with illegal=1; every recognised type SHALL have illegal=0.
REQ-022 SHALL extract the fields as follows: dest_reg=[4:0]; regnum_1=[9:5]; regnum_2=[20:16]; shammt=[15:10]; address=[12+ADDR_W-1:12].
REQ-023 SHALL drive in_ready = (count < DEPTH), with no combinational dependence on out_ready.
REQ-024 SHALL drive out_valid = (count != 0), with all output fields presenting the head entry combinationally from storage.
REQ-025 SHALL give a minimum latency of one cycle: an instruction accepted at edge N appears with out_valid=1 after edge N.
REQ-026 SHALL remove the head entry on out_valid && out_ready and advance the read pointer modulo DEPTH.
REQ-027 SHALL advance the write pointer modulo DEPTH on each accept; pointer wrap-around SHALL be transparent to the data.
REQ-028 SHALL, on a simultaneous accept and remove, leave count unchanged; both pointers SHALL advance.
REQ-029 SHALL ignore out_ready while empty; SHALL never accept while full, since in_ready=0.
REQ-030 SHALL, when flush=1, zero both pointers and count on that edge and discard any same-cycle accept or remove.
REQ-031 SHALL hold output fields at the last head contents when empty; consumers SHALL qualify them with out_valid.

Reset
REQ-032 SHALL, while rst_n=0, asynchronously clear the pointers and count to 0, giving out_valid=0, in_ready=1 and count=0.
REQ-033 SHALL clear all storage entries to zero on reset, so that type_instruction=0000, illegal=0 and all fields read 0 while reset is applied.
REQ-034 SHALL discard any operation in flight when reset is asserted mid-operation; the first accept after release SHALL be possible on the first edge with rst_n=1.

Configuration
REQ-035 SHALL compile immediate decoding in when macro SIMD_DECODE_IMM_EN is defined: [31:22]=1001000100→1000 ADDI and [31:22]=1101000100→1001 SUBI, with immediate=[21:10] stored per entry.
REQ-036 SHALL, without SIMD_DECODE_IMM_EN, decode those encodings as illegal (1111), tie immediate to 0 and include no immediate storage.

Verification
REQ-037 SHALL be verified by this scenario: push 0x8B020020 → next cycle out_valid=1, type=0000, dest=0, regnum_1=1, regnum_2=2, illegal=0.
REQ-038 SHALL be verified by this scenario: with DEPTH=4 and out_ready=0, push 5 words → in_ready=0 after the 4th, the 5th is not accepted, count=4, and draining returns FIFO order.
REQ-039 SHALL be verified by this scenario: full queue, then in_valid=1 and out_ready=1 for 8 cycles → in_ready=0 on the first cycle, afterwards count stays 3/4 with pointer wrap, and the data order is preserved.
REQ-040 SHALL be verified by this scenario: push 0x1E632820 (FADD), 0x1E633820 (FSUB) and 0xFFFFFFFF → types 0100, 0101 and 1111 with illegal=1.
REQ-041 SHALL be verified by this scenario: with the macro defined, push 0x91002820 → type=1000, immediate=0x00A; without the macro → type=1111, immediate=0.
REQ-042 SHALL be verified by this scenario: count=3, then flush=1 with a simultaneous push → count=0 and out_valid=0; separately, asserting rst_n=0 mid-stream → outputs clear immediately, without waiting for a clock edge.
